// File: rtl/timer_cnt_core_pkg.sv
// Shared timer constants: data/count widths, compare reset value, half selectors.
// Other debug-aware timer blocks import this package too.
package timer_cnt_core_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2 * DATA_W;

  localparam logic [CNT_W-1:0] CMP_RST = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam int LO = 0;
  localparam int HI = 1;

  // Replace one DATA_W-wide half of a CNT_W-wide value.
  function automatic logic [CNT_W-1:0] set_half(input logic [CNT_W-1:0] val,
                                                input int                sel,
                                                input logic [DATA_W-1:0] data);
    logic [CNT_W-1:0] res;
    res = val;
    res[sel*DATA_W +: DATA_W] = data;
    return res;
  endfunction

endpackage

// File: rtl/timer_cnt_core_if.sv
// Register-decode / counter_control side bus of timer_cnt_core.
// The master modport is the decode side. The slave modport is the timer core.
interface timer_cnt_core_if;
  import timer_cnt_core_pkg::*;

  logic              cnt_en;
  logic              timer_en;
  logic              wr_cnt_lo;
  logic              wr_cnt_hi;
  logic              wr_cmp_lo;
  logic              wr_cmp_hi;
  logic [DATA_W-1:0] wdata;
  logic              int_en;
  logic              int_st_clr;
  logic              dbg_mode;
  logic              halt_req;
  logic [CNT_W-1:0]  cnt_val;
  logic [CNT_W-1:0]  cmp_val;
  logic              int_st;
  logic              tim_int;
  logic              halt_ack;

  modport master (
    output cnt_en, timer_en, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi,
           wdata, int_en, int_st_clr, dbg_mode, halt_req,
    input  cnt_val, cmp_val, int_st, tim_int, halt_ack
  );

  modport slave (
    input  cnt_en, timer_en, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi,
           wdata, int_en, int_st_clr, dbg_mode, halt_req,
    output cnt_val, cmp_val, int_st, tim_int, halt_ack
  );

endinterface

// File: rtl/timer_halt_ack.sv
// Registered debug-halt acknowledge. It asserts one cycle after a halt request in debug mode.
// It drops one cycle after the request or debug mode goes away.
module timer_halt_ack (
  input  logic CLK,
  input  logic RST,
  input  logic i_halt_req,
  input  logic i_dbg_mode,
  output logic o_halt_ack
);

  logic r_halt_ack;

  // NOTE: the reset is synchronous, so RST sits inside the clocked branch and is not in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_halt_ack <= 1'b0;
    end else begin
      r_halt_ack <= i_halt_req & i_dbg_mode;
    end
  end

  assign o_halt_ack = r_halt_ack;

endmodule

// File: rtl/timer_cnt_core.sv
// 64-bit timer count and compare registers with a sticky compare interrupt.
// Half-register software writes take priority over the disable-clear and the tick increment.
module timer_cnt_core
  import timer_cnt_core_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  timer_cnt_core_if.slave  bus
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cmp;
  logic             r_int_st;
  logic             r_timer_en_q;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cmp_nxt;
  logic             w_int_st_nxt;
  logic             w_halt_ack;
  logic             w_cnt_wr;
  logic             w_tim_fall;
  logic             w_match;

  timer_halt_ack u_halt_ack (
    .CLK        (CLK),
    .RST        (RST),
    .i_halt_req (bus.halt_req),
    .i_dbg_mode (bus.dbg_mode),
    .o_halt_ack (w_halt_ack)
  );

  assign w_cnt_wr   = bus.wr_cnt_lo | bus.wr_cnt_hi;
  assign w_tim_fall = r_timer_en_q & ~bus.timer_en;
  assign w_match    = (r_cnt == r_cmp);

  // A write to either half blocks the clear and the increment for the whole 64-bit value.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_cnt_wr) begin
      if (bus.wr_cnt_lo) w_cnt_nxt = set_half(w_cnt_nxt, LO, bus.wdata);
      if (bus.wr_cnt_hi) w_cnt_nxt = set_half(w_cnt_nxt, HI, bus.wdata);
    end else if (w_tim_fall) begin
      w_cnt_nxt = '0;
    end else if (bus.cnt_en && !w_halt_ack) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
  end

  always_comb begin
    w_cmp_nxt = r_cmp;
    if (bus.wr_cmp_lo) w_cmp_nxt = set_half(w_cmp_nxt, LO, bus.wdata);
    if (bus.wr_cmp_hi) w_cmp_nxt = set_half(w_cmp_nxt, HI, bus.wdata);
  end

  // If a match and a clear arrive in the same cycle, the match wins.
  always_comb begin
    w_int_st_nxt = r_int_st;
    if (w_match) begin
      w_int_st_nxt = 1'b1;
    end else if (bus.int_st_clr) begin
      w_int_st_nxt = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every register samples values from before the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt        <= '0;
      r_cmp        <= CMP_RST;
      r_int_st     <= 1'b0;
      r_timer_en_q <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_cmp        <= w_cmp_nxt;
      r_int_st     <= w_int_st_nxt;
      r_timer_en_q <= bus.timer_en;
    end
  end

  assign bus.cnt_val  = r_cnt;
  assign bus.cmp_val  = r_cmp;
  assign bus.int_st   = r_int_st;
  assign bus.tim_int  = r_int_st & bus.int_en;
  assign bus.halt_ack = w_halt_ack;

endmodule

// File: tb/tb_timer_cnt_core.sv
// Directed testbench for timer_cnt_core. Each scenario task computes its expected values by hand.
module tb_timer_cnt_core;
  import timer_cnt_core_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  timer_cnt_core_if bus ();

  timer_cnt_core dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_strobes();
    bus.wr_cnt_lo  = 1'b0;
    bus.wr_cnt_hi  = 1'b0;
    bus.wr_cmp_lo  = 1'b0;
    bus.wr_cmp_hi  = 1'b0;
    bus.int_st_clr = 1'b0;
    bus.cnt_en     = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    n_checks++;
    if (bus.cnt_val !== 64'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %h want %h", bus.cnt_val, 64'h0);
    end
    n_checks++;
    if (bus.cmp_val !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL reset_cmp: got %h want %h", bus.cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    n_checks++;
    if (bus.int_st !== 1'b0 || bus.halt_ack !== 1'b0 || bus.tim_int !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got int_st=%b halt_ack=%b tim_int=%b want 000",
                         bus.int_st, bus.halt_ack, bus.tim_int);
    end
    bus.timer_en = 1'b1;
    tick();
    bus.cnt_en = 1'b1;
    tick(5);
    bus.cnt_en = 1'b0;
    n_checks++;
    if (bus.cnt_val !== 64'h5) begin
      n_fail++; $display("FAIL count5: got %h want %h", bus.cnt_val, 64'h5);
    end
    n_checks++;
    if (bus.int_st !== 1'b0 || bus.halt_ack !== 1'b0 || bus.cmp_val !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL count5_side: got int_st=%b halt_ack=%b cmp=%h", bus.int_st,
                         bus.halt_ack, bus.cmp_val);
    end
  endtask

  task automatic test_wrap();
    bus.wr_cnt_lo = 1'b1; bus.wr_cnt_hi = 1'b1; bus.wdata = 32'hFFFF_FFFF;
    tick();
    clear_strobes();
    n_checks++;
    if (bus.cnt_val !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL atomic_load: got %h want all ones", bus.cnt_val);
    end
    bus.cnt_en = 1'b1;
    tick();
    bus.cnt_en = 1'b0;
    n_checks++;
    if (bus.cnt_val !== 64'h0) begin
      n_fail++; $display("FAIL wrap: got %h want %h", bus.cnt_val, 64'h0);
    end
    // The count matched the all-ones compare value, so int_st is set even with int_en low.
    n_checks++;
    if (bus.int_st !== 1'b1 || bus.tim_int !== 1'b0) begin
      n_fail++; $display("FAIL wrap_int_unmasked: got int_st=%b tim_int=%b want 1 0",
                         bus.int_st, bus.tim_int);
    end
    bus.int_st_clr = 1'b1;
    tick();
    clear_strobes();
    n_checks++;
    if (bus.int_st !== 1'b0) begin
      n_fail++; $display("FAIL wrap_int_clr: got %b want 0", bus.int_st);
    end
    bus.wr_cnt_lo = 1'b1; bus.wdata = 32'hFFFF_FFFF;
    tick();
    clear_strobes();
    bus.wr_cnt_hi = 1'b1; bus.wdata = 32'h0;
    tick();
    clear_strobes();
    bus.cnt_en = 1'b1;
    tick();
    bus.cnt_en = 1'b0;
    n_checks++;
    if (bus.cnt_val !== 64'h1_0000_0000) begin
      n_fail++; $display("FAIL carry: got %h want %h", bus.cnt_val, 64'h1_0000_0000);
    end
  endtask

  task automatic test_compare();
    bus.wr_cmp_lo = 1'b1; bus.wdata = 32'h10;
    tick();
    clear_strobes();
    bus.wr_cmp_hi = 1'b1; bus.wdata = 32'h0;
    tick();
    clear_strobes();
    bus.wr_cnt_lo = 1'b1; bus.wr_cnt_hi = 1'b1; bus.wdata = 32'h0;
    tick();
    clear_strobes();
    n_checks++;
    if (bus.cmp_val !== 64'h10 || bus.cnt_val !== 64'h0) begin
      n_fail++; $display("FAIL cmp_load: got cmp=%h cnt=%h want 10 0", bus.cmp_val, bus.cnt_val);
    end
    bus.int_en = 1'b1;
    bus.cnt_en = 1'b1;
    tick(16);
    bus.cnt_en = 1'b0;
    n_checks++;
    if (bus.cnt_val !== 64'h10 || bus.int_st !== 1'b0) begin
      n_fail++; $display("FAIL match_cycle: got cnt=%h int_st=%b want 10 0", bus.cnt_val, bus.int_st);
    end
    tick();
    n_checks++;
    if (bus.int_st !== 1'b1 || bus.tim_int !== 1'b1) begin
      n_fail++; $display("FAIL int_set: got int_st=%b tim_int=%b want 1 1", bus.int_st, bus.tim_int);
    end
    bus.int_st_clr = 1'b1;
    tick();
    clear_strobes();
    n_checks++;
    if (bus.int_st !== 1'b1) begin
      n_fail++; $display("FAIL clr_while_match: got %b want 1", bus.int_st);
    end
    bus.cnt_en = 1'b1;
    tick();
    bus.cnt_en = 1'b0;
    bus.int_st_clr = 1'b1;
    tick();
    clear_strobes();
    n_checks++;
    if (bus.cnt_val !== 64'h11 || bus.int_st !== 1'b0 || bus.tim_int !== 1'b0) begin
      n_fail++; $display("FAIL clr_after_match: got cnt=%h int_st=%b tim_int=%b want 11 0 0",
                         bus.cnt_val, bus.int_st, bus.tim_int);
    end
  endtask

  task automatic test_halt();
    bus.dbg_mode = 1'b1; bus.halt_req = 1'b1;
    tick();
    n_checks++;
    if (bus.halt_ack !== 1'b1) begin
      n_fail++; $display("FAIL halt_ack_rise: got %b want 1", bus.halt_ack);
    end
    bus.cnt_en = 1'b1;
    tick(3);
    n_checks++;
    if (bus.cnt_val !== 64'h11) begin
      n_fail++; $display("FAIL halt_freeze: got %h want %h", bus.cnt_val, 64'h11);
    end
    bus.wr_cnt_lo = 1'b1; bus.wdata = 32'h20;
    tick();
    bus.wr_cnt_lo = 1'b0;
    n_checks++;
    if (bus.cnt_val !== 64'h20) begin
      n_fail++; $display("FAIL halt_write: got %h want %h", bus.cnt_val, 64'h20);
    end
    bus.dbg_mode = 1'b0;
    tick();
    n_checks++;
    if (bus.halt_ack !== 1'b0 || bus.cnt_val !== 64'h20) begin
      n_fail++; $display("FAIL halt_ack_fall: got ack=%b cnt=%h want 0 20", bus.halt_ack, bus.cnt_val);
    end
    tick();
    bus.cnt_en = 1'b0; bus.halt_req = 1'b0;
    n_checks++;
    if (bus.cnt_val !== 64'h21) begin
      n_fail++; $display("FAIL halt_resume: got %h want %h", bus.cnt_val, 64'h21);
    end
  endtask

  task automatic test_disable_clear();
    bus.wr_cnt_lo = 1'b1; bus.wdata = 32'h1234;
    tick();
    clear_strobes();
    bus.timer_en = 1'b0;
    tick();
    n_checks++;
    if (bus.cnt_val !== 64'h0) begin
      n_fail++; $display("FAIL disable_clear: got %h want %h", bus.cnt_val, 64'h0);
    end
    bus.timer_en = 1'b1;
    bus.wr_cnt_lo = 1'b1; bus.wdata = 32'h1234;
    tick();
    clear_strobes();
    n_checks++;
    if (bus.cnt_val !== 64'h1234) begin
      n_fail++; $display("FAIL rise_no_effect: got %h want %h", bus.cnt_val, 64'h1234);
    end
    bus.timer_en = 1'b0;
    bus.wr_cnt_lo = 1'b1; bus.wdata = 32'hAA;
    tick();
    clear_strobes();
    tick();
    n_checks++;
    if (bus.cnt_val !== 64'hAA) begin
      n_fail++; $display("FAIL write_beats_clear: got %h want %h", bus.cnt_val, 64'hAA);
    end
    bus.timer_en = 1'b1;
    tick();
  endtask

  task automatic test_write_vs_inc();
    bus.wr_cnt_lo = 1'b1; bus.wdata = 32'h7;
    tick();
    clear_strobes();
    bus.wr_cnt_hi = 1'b1; bus.wdata = 32'h5; bus.cnt_en = 1'b1;
    tick();
    clear_strobes();
    n_checks++;
    if (bus.cnt_val !== 64'h5_0000_0007) begin
      n_fail++; $display("FAIL write_vs_inc: got %h want %h", bus.cnt_val, 64'h5_0000_0007);
    end
  endtask

  task automatic test_back_to_back();
    bus.wr_cmp_lo = 1'b1; bus.wdata = 32'h7;
    tick();
    clear_strobes();
    bus.wr_cmp_hi = 1'b1; bus.wdata = 32'h5;
    tick();
    clear_strobes();
    n_checks++;
    if (bus.cmp_val !== 64'h5_0000_0007 || bus.cnt_val !== 64'h5_0000_0007) begin
      n_fail++; $display("FAIL cmp_no_cnt_effect: got cmp=%h cnt=%h want both 500000007",
                         bus.cmp_val, bus.cnt_val);
    end
    // Reset lands together with a live match, a pending write and a halt request.
    RST = 1'b1;
    bus.wr_cnt_lo = 1'b1; bus.wdata = 32'h99;
    bus.dbg_mode = 1'b1; bus.halt_req = 1'b1; bus.cnt_en = 1'b1;
    tick();
    RST = 1'b0;
    clear_strobes();
    bus.dbg_mode = 1'b0; bus.halt_req = 1'b0;
    n_checks++;
    if (bus.cnt_val !== 64'h0 || bus.cmp_val !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL midrst_regs: got cnt=%h cmp=%h", bus.cnt_val, bus.cmp_val);
    end
    n_checks++;
    if (bus.int_st !== 1'b0 || bus.halt_ack !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags: got int_st=%b halt_ack=%b want 0 0",
                         bus.int_st, bus.halt_ack);
    end
  endtask

  initial begin
    clear_strobes();
    bus.timer_en = 1'b0;
    bus.wdata    = '0;
    bus.int_en   = 1'b0;
    bus.dbg_mode = 1'b0;
    bus.halt_req = 1'b0;
    test_reset();
    test_wrap();
    test_compare();
    test_halt();
    test_disable_clear();
    test_write_vs_inc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
